// File: rtl/uart_dbg_pkg.sv
// Shared constants and state encodings for the UART-to-APB debug bridge.
package uart_dbg_pkg;

   localparam logic [7:0] CMD_WR  = 8'h57;
   localparam logic [7:0] CMD_RD  = 8'h52;
   localparam logic [7:0] RSP_OK  = 8'hAC;
   localparam logic [7:0] RSP_ERR = 8'hEE;

   typedef enum logic [2:0] {
      F_CMD,
      F_ADDR,
      F_WDATA,
      F_SETUP,
      F_ACCESS,
      F_RESP
   } frame_state_e;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } bit_state_e;

endpackage

// File: rtl/apb_intf.sv
// APB bus bundle; the bridge uses the master view.
interface apb_intf;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (output psel, penable, pwrite, paddr, pwdata,
                   input  prdata, pready, pslverr);
   modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                   output prdata, pready, pslverr);
endinterface

// File: rtl/uart_dbg_serdes.sv
// 8N1 serial engines: synchronised receiver with glitch-rejecting start
// check, and a registered transmitter with a valid/ready byte handshake.
module uart_dbg_serdes
   import uart_dbg_pkg::*;
#(
   parameter int N_SYNC = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] div,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        rx_vld,
   output logic [7:0]  rx_data,
   output logic        frm_err,
   output logic        rx_idle,
   input  logic        tx_vld,
   output logic        tx_rdy,
   input  logic [7:0]  tx_data,
   output logic        tx_idle
);

   logic [N_SYNC-1:0] sync_q;
   logic              rx_s;
   bit_state_e        rx_st_q, rx_st_d;
   logic [15:0]       rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
   logic [2:0]        rx_bit_q, rx_bit_d;
   logic [7:0]        rx_sh_q, rx_sh_d;
   logic              rx_end;

   bit_state_e        tx_st_q, tx_st_d;
   logic [15:0]       tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
   logic [2:0]        tx_bit_q, tx_bit_d;
   logic [7:0]        tx_sh_q, tx_sh_d;
   logic              tx_q, tx_d;
   logic              tx_end;

   assign rx_s    = sync_q[N_SYNC-1];
   assign rx_end  = (rx_cnt_q == rx_div_q);
   assign rx_vld  = (rx_st_q == STOP) && rx_end && rx_s;
   assign frm_err = (rx_st_q == STOP) && rx_end && !rx_s;
   assign rx_data = rx_sh_q;
   assign rx_idle = (rx_st_q == IDLE);

   assign tx_end  = (tx_cnt_q == tx_div_q);
   assign tx_rdy  = (tx_st_q == IDLE) || ((tx_st_q == STOP) && tx_end);
   assign tx_idle = (tx_st_q == IDLE);
   assign uart_tx = tx_q;

   // Receive bit engine next state: half-bit start recheck, then mid-bit samples.
   always_comb begin
      rx_st_d  = rx_st_q;
      rx_cnt_d = rx_cnt_q + 16'd1;
      rx_div_d = rx_div_q;
      rx_bit_d = rx_bit_q;
      rx_sh_d  = rx_sh_q;
      unique case (rx_st_q)
         IDLE: begin
            rx_cnt_d = '0;
            if (!rx_s) begin
               rx_st_d  = START;
               rx_div_d = div;
            end
         end
         START: begin
            if (rx_cnt_q == {1'b0, rx_div_q[15:1]}) begin
               rx_cnt_d = '0;
               rx_bit_d = '0;
               rx_st_d  = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (rx_end) begin
               rx_cnt_d = '0;
               rx_sh_d  = {rx_s, rx_sh_q[7:1]};
               rx_bit_d = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_st_d = STOP;
            end
         end
         STOP: begin
            if (rx_end) begin
               rx_cnt_d = '0;
               rx_st_d  = IDLE;
            end
         end
         default: rx_st_d = IDLE;
      endcase
   end

   // Transmit bit engine next state; a new byte may chain straight off a stop bit.
   always_comb begin
      tx_st_d  = tx_st_q;
      tx_cnt_d = tx_end ? 16'd0 : tx_cnt_q + 16'd1;
      tx_div_d = tx_div_q;
      tx_bit_d = tx_bit_q;
      tx_sh_d  = tx_sh_q;
      tx_d     = tx_q;
      unique case (tx_st_q)
         IDLE: tx_cnt_d = '0;
         START: begin
            if (tx_end) begin
               tx_st_d  = DATA;
               tx_bit_d = '0;
               tx_d     = tx_sh_q[0];
            end
         end
         DATA: begin
            if (tx_end) begin
               if (tx_bit_q == 3'd7) begin
                  tx_st_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  tx_bit_d = tx_bit_q + 3'd1;
                  tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                  tx_d     = tx_sh_q[1];
               end
            end
         end
         STOP: if (tx_end) tx_st_d = IDLE;
         default: tx_st_d = IDLE;
      endcase
      if (tx_vld && tx_rdy) begin
         tx_st_d  = START;
         tx_cnt_d = '0;
         tx_div_d = div;
         tx_sh_d  = tx_data;
         tx_d     = 1'b0;
      end
   end

   // State registers for synchroniser and both bit engines.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '1;
         rx_st_q  <= IDLE;
         rx_cnt_q <= '0;
         rx_div_q <= '0;
         rx_bit_q <= '0;
         rx_sh_q  <= '0;
         tx_st_q  <= IDLE;
         tx_cnt_q <= '0;
         tx_div_q <= '0;
         tx_bit_q <= '0;
         tx_sh_q  <= '0;
         tx_q     <= 1'b1;
      end else begin
         sync_q   <= {sync_q[N_SYNC-2:0], uart_rx};
         rx_st_q  <= rx_st_d;
         rx_cnt_q <= rx_cnt_d;
         rx_div_q <= rx_div_d;
         rx_bit_q <= rx_bit_d;
         rx_sh_q  <= rx_sh_d;
         tx_st_q  <= tx_st_d;
         tx_cnt_q <= tx_cnt_d;
         tx_div_q <= tx_div_d;
         tx_bit_q <= tx_bit_d;
         tx_sh_q  <= tx_sh_d;
         tx_q     <= tx_d;
      end
   end

endmodule

// File: rtl/uart_dbg_master.sv
// UART-to-APB debug bridge top: frame decoding, inter-byte timeout,
// single APB transfer sequencing and response generation.
module uart_dbg_master
   import uart_dbg_pkg::*;
#(
   parameter logic [15:0] TIMEOUT = 16'hFFFF,
   parameter int          N_SYNC  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] div,
   input  logic        uart_rx,
   output logic        uart_tx,
   apb_intf.master     m_apb_intf,
   output logic        busy
);

   frame_state_e state_q, state_d;
   logic         rx_vld, frm_err, rx_idle, tx_vld, tx_rdy, tx_idle;
   logic [7:0]   rx_data, tx_byte;
   logic         is_wr_q, slverr_q, rsp_done_q;
   logic [1:0]   cnt_q;
   logic [15:0]  gap_q;
   logic [2:0]   rsp_idx_q;
   logic [31:0]  addr_sr_q, wd_sr_q, prdata_q;
   logic         psel_q, penable_q, pwrite_q;
   logic [31:0]  paddr_q, pwdata_q;
   logic         gap_hit;

   uart_dbg_serdes #(.N_SYNC(N_SYNC)) u_serdes (
      .clk     (clk),
      .rst     (rst),
      .div     (div),
      .uart_rx (uart_rx),
      .uart_tx (uart_tx),
      .rx_vld  (rx_vld),
      .rx_data (rx_data),
      .frm_err (frm_err),
      .rx_idle (rx_idle),
      .tx_vld  (tx_vld),
      .tx_rdy  (tx_rdy),
      .tx_data (tx_byte),
      .tx_idle (tx_idle)
   );

   assign m_apb_intf.psel    = psel_q;
   assign m_apb_intf.penable = penable_q;
   assign m_apb_intf.pwrite  = pwrite_q;
   assign m_apb_intf.paddr   = paddr_q;
   assign m_apb_intf.pwdata  = pwdata_q;

   // The idle gap only advances while the receiver sits between bytes.
   assign gap_hit = rx_idle && !rx_vld && ((gap_q + 16'd1) == TIMEOUT);

   // Frame state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= F_CMD;
      else     state_q <= state_d;
   end

   // Frame next-state decode.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         F_CMD:
            if (rx_vld && ((rx_data == CMD_WR) || (rx_data == CMD_RD))) state_d = F_ADDR;
         F_ADDR:
            if (frm_err)                    state_d = F_CMD;
            else if (rx_vld && cnt_q == 2'd3) state_d = is_wr_q ? F_WDATA : F_SETUP;
            else if (gap_hit)               state_d = F_CMD;
         F_WDATA:
            if (frm_err)                    state_d = F_CMD;
            else if (rx_vld && cnt_q == 2'd3) state_d = F_SETUP;
            else if (gap_hit)               state_d = F_CMD;
         F_SETUP:  state_d = F_ACCESS;
         F_ACCESS: if (m_apb_intf.pready) state_d = F_RESP;
         F_RESP:   if (rsp_done_q && tx_idle) state_d = F_CMD;
         default:  state_d = F_CMD;
      endcase
   end

   // Frame outputs: busy flag and the response byte offered to the transmitter.
   always_comb begin
      busy    = (state_q != F_CMD);
      tx_vld  = (state_q == F_RESP) && !rsp_done_q;
      tx_byte = (rsp_idx_q == 3'd4) ? (slverr_q ? RSP_ERR : RSP_OK)
                                    : prdata_q[8*rsp_idx_q[1:0] +: 8];
   end

   // Datapath: byte assembly, gap counter, APB registers and response pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         is_wr_q    <= 1'b0;
         cnt_q      <= '0;
         gap_q      <= '0;
         addr_sr_q  <= '0;
         wd_sr_q    <= '0;
         prdata_q   <= '0;
         slverr_q   <= 1'b0;
         rsp_idx_q  <= '0;
         rsp_done_q <= 1'b0;
         psel_q     <= 1'b0;
         penable_q  <= 1'b0;
         pwrite_q   <= 1'b0;
         paddr_q    <= '0;
         pwdata_q   <= '0;
      end else begin
         unique case (state_q)
            F_CMD: begin
               cnt_q <= '0;
               gap_q <= '0;
               if (rx_vld) is_wr_q <= (rx_data == CMD_WR);
            end
            F_ADDR, F_WDATA: begin
               if (rx_vld) begin
                  cnt_q <= cnt_q + 2'd1;
                  gap_q <= '0;
                  if (state_q == F_ADDR) addr_sr_q <= {rx_data, addr_sr_q[31:8]};
                  else                   wd_sr_q   <= {rx_data, wd_sr_q[31:8]};
               end else if (rx_idle) begin
                  gap_q <= gap_q + 16'd1;
               end
            end
            F_ACCESS: begin
               if (m_apb_intf.pready) begin
                  prdata_q   <= m_apb_intf.prdata;
                  slverr_q   <= m_apb_intf.pslverr;
                  rsp_idx_q  <= is_wr_q ? 3'd4 : 3'd0;
                  rsp_done_q <= 1'b0;
               end
            end
            default: ;
         endcase

         if (tx_vld && tx_rdy) begin
            if (rsp_idx_q == 3'd4) rsp_done_q <= 1'b1;
            else                   rsp_idx_q  <= rsp_idx_q + 3'd1;
         end

         // Bus strobes track the state being entered so they are registered.
         psel_q    <= (state_d == F_SETUP) || (state_d == F_ACCESS);
         penable_q <= (state_d == F_ACCESS);

         // Address/data are loaded once on entry to setup and then held.
         if (state_d == F_SETUP && state_q != F_SETUP) begin
            if (state_q == F_ADDR) begin
               paddr_q  <= {rx_data, addr_sr_q[31:8]};
               pwrite_q <= 1'b0;
            end else begin
               paddr_q  <= addr_sr_q;
               pwdata_q <= {rx_data, wd_sr_q[31:8]};
               pwrite_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_dbg_master.sv
// Directed bench for the UART-to-APB bridge with a serial host model,
// a response decoder and a wait-state capable APB slave.
module tb_uart_dbg_master;
   import uart_dbg_pkg::*;

   localparam int BIT = 4;   // div=3

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] div = 16'd3;
   logic        uart_rx = 1'b1;
   logic        uart_tx;
   logic        busy;

   apb_intf apb ();

   uart_dbg_master #(.TIMEOUT(16'd100), .N_SYNC(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .div        (div),
      .uart_rx    (uart_rx),
      .uart_tx    (uart_tx),
      .m_apb_intf (apb),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Response decoder state (written only by the decoder process).
   logic [7:0] rsp_bytes [0:1023];
   int         rsp_n  = 0;
   int         tx_bad = 0;

   // Slave model state (written only by the slave process).
   int          wait_n = 0;
   int          xfer_cnt = 0, acc_cnt = 0, setup_cnt = 0, psel_cnt = 0;
   logic [31:0] last_addr = '0, last_wdata = '0;
   logic        last_write = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bit_wait();
      repeat (BIT) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      uart_rx = 1'b0;
      bit_wait();
      for (int k = 0; k < 8; k++) begin
         uart_rx = b[k];
         bit_wait();
      end
      uart_rx = stop;
      bit_wait();
      uart_rx = 1'b1;
   endtask

   task automatic send_read(input logic [31:0] addr);
      send_byte(CMD_RD, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], 1'b1);
   endtask

   task automatic send_write(input logic [31:0] addr, input logic [31:0] data);
      send_byte(CMD_WR, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], 1'b1);
      for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8], 1'b1);
   endtask

   task automatic wait_not_busy(input string tag);
      int n;
      n = 0;
      while (busy && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(n < 3000), 32'd1);
      repeat (5) @(negedge clk);
   endtask

   // Checks a received response against five expected bytes (n of them used).
   task automatic chk_resp(input string tag, input int base, input int n,
                           input logic [39:0] exp);
      chk({tag, "_len"}, 32'(rsp_n - base), 32'(n));
      for (int i = 0; i < n; i++)
         chk({tag, "_byte"}, 32'(rsp_bytes[(base + i) % 1024]), 32'(exp[8*i +: 8]));
   endtask

   // Serial response decoder: samples mid-bit relative to the start edge.
   initial begin
      logic [7:0] b;
      b = '0;
      forever begin
         @(negedge clk);
         if (uart_tx === 1'b0 && !rst) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++) begin
               repeat (BIT) @(negedge clk);
               b[k] = uart_tx;
            end
            repeat (BIT) @(negedge clk);
            if (uart_tx !== 1'b1) tx_bad++;
            rsp_bytes[rsp_n % 1024] = b;
            rsp_n++;
         end
      end
   end

   // APB slave with programmable wait states, sampled mid-cycle.
   initial begin
      int wcnt;
      wcnt = 0;
      apb.pready = 1'b0;
      forever begin
         @(negedge clk);
         if (apb.psel === 1'b1) psel_cnt++;
         if (apb.psel === 1'b1 && apb.penable === 1'b1) begin
            acc_cnt++;
            if (wcnt < wait_n) begin
               apb.pready = 1'b0;
               wcnt++;
            end else begin
               apb.pready = 1'b1;
               xfer_cnt++;
               last_addr  = apb.paddr;
               last_wdata = apb.pwdata;
               last_write = apb.pwrite;
            end
         end else begin
            apb.pready = 1'b0;
            wcnt = 0;
            if (apb.psel === 1'b1) setup_cnt++;
         end
      end
   end

   initial begin
      int xb, ab, sb, rb, pb, n;
      apb.prdata  = '0;
      apb.pslverr = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx", 32'(uart_tx), 32'd1);
      chk("rst_psel", 32'(apb.psel), 32'd0);
      chk("rst_penable", 32'(apb.penable), 32'd0);
      chk("rst_pwrite", 32'(apb.pwrite), 32'd0);
      chk("rst_paddr", apb.paddr, 32'd0);
      chk("rst_pwdata", apb.pwdata, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      // Write with zero wait states
      xb = xfer_cnt; ab = acc_cnt; sb = setup_cnt; rb = rsp_n;
      wait_n = 0;
      send_byte(CMD_WR, 1'b1);
      send_byte(8'h10, 1'b1);
      chk("wr_busy_mid", 32'(busy), 32'd1);
      send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h40, 1'b1);
      send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1);
      send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
      wait_not_busy("wr_done");
      chk("wr_xfers", 32'(xfer_cnt - xb), 32'd1);
      chk("wr_paddr", last_addr, 32'h4000_0010);
      chk("wr_pwdata", last_wdata, 32'hDEAD_BEEF);
      chk("wr_pwrite", 32'(last_write), 32'd1);
      chk("wr_setup", 32'(setup_cnt - sb), 32'd1);
      chk("wr_access", 32'(acc_cnt - ab), 32'd1);
      chk("wr_psel_idle", 32'(apb.psel), 32'd0);
      chk("wr_paddr_hold", apb.paddr, 32'h4000_0010);
      chk_resp("wr_rsp", rb, 1, 40'hAC);
      chk("wr_tx_idle", 32'(uart_tx), 32'd1);
      $display("[TB] write 40000010<=deadbeef resp=%0d byte(s)", rsp_n - rb);

      // Read with five wait states
      xb = xfer_cnt; ab = acc_cnt; sb = setup_cnt; rb = rsp_n;
      wait_n = 5;
      apb.prdata = 32'h1234_5678; apb.pslverr = 1'b0;
      send_read(32'h4000_0004);
      wait_not_busy("rd_done");
      chk("rd_xfers", 32'(xfer_cnt - xb), 32'd1);
      chk("rd_paddr", last_addr, 32'h4000_0004);
      chk("rd_pwrite", 32'(last_write), 32'd0);
      chk("rd_setup", 32'(setup_cnt - sb), 32'd1);
      chk("rd_access", 32'(acc_cnt - ab), 32'd6);
      chk_resp("rd_rsp", rb, 5, 40'hAC_12_34_56_78);
      $display("[TB] read 40000004 wait=5 resp=%0d byte(s)", rsp_n - rb);

      // Read answered with a slave error
      xb = xfer_cnt; rb = rsp_n;
      wait_n = 0;
      apb.prdata = 32'h0; apb.pslverr = 1'b1;
      send_read(32'h4000_0008);
      wait_not_busy("err_done");
      chk("err_xfers", 32'(xfer_cnt - xb), 32'd1);
      chk_resp("err_rsp", rb, 5, 40'hEE_00_00_00_00);
      $display("[TB] read 40000008 pslverr resp=%0d byte(s)", rsp_n - rb);

      // Partial write abandoned by the gap timeout, then a full read
      xb = xfer_cnt; rb = rsp_n;
      apb.pslverr = 1'b0; apb.prdata = 32'hA5A5_0001;
      send_byte(CMD_WR, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
      repeat (150) @(negedge clk);
      chk("to_busy", 32'(busy), 32'd0);
      chk("to_no_xfer", 32'(xfer_cnt - xb), 32'd0);
      send_read(32'h4000_0000);
      wait_not_busy("to_rd_done");
      chk("to_xfers", 32'(xfer_cnt - xb), 32'd1);
      chk("to_paddr", last_addr, 32'h4000_0000);
      chk("to_pwrite", 32'(last_write), 32'd0);
      chk_resp("to_rsp", rb, 5, 40'hAC_A5_A5_00_01);
      $display("[TB] timeout then read 40000000 resp=%0d byte(s)", rsp_n - rb);

      // Framing error and unknown command are ignored
      xb = xfer_cnt; pb = psel_cnt; rb = rsp_n;
      apb.prdata = 32'hCAFE_F00D;
      send_byte(CMD_WR, 1'b0);
      repeat (60) @(negedge clk);
      send_byte(8'h33, 1'b1);
      repeat (60) @(negedge clk);
      chk("junk_busy", 32'(busy), 32'd0);
      chk("junk_no_psel", 32'(psel_cnt - pb), 32'd0);
      send_read(32'h4000_000C);
      wait_not_busy("junk_rd_done");
      chk("junk_xfers", 32'(xfer_cnt - xb), 32'd1);
      chk("junk_paddr", last_addr, 32'h4000_000C);
      chk_resp("junk_rsp", rb, 5, 40'hAC_CA_FE_F0_0D);
      chk("tx_stop_bits", 32'(tx_bad), 32'd0);
      $display("[TB] junk then read 4000000c resp=%0d byte(s)", rsp_n - rb);

      // Reset during a stalled access
      wait_n = 50;
      send_read(32'h4000_0014);
      n = 0;
      while (apb.penable !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("rsta_reached", 32'(n < 500), 32'd1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rsta_psel", 32'(apb.psel), 32'd0);
      chk("rsta_penable", 32'(apb.penable), 32'd0);
      chk("rsta_tx", 32'(uart_tx), 32'd1);
      chk("rsta_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      wait_n = 0;
      repeat (20) @(negedge clk);
      $display("[TB] reset during access");

      // Reset during a response byte
      apb.prdata = 32'h0;
      send_write(32'h4000_0018, 32'h0000_0001);
      n = 0;
      while (uart_tx !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("rstt_reached", 32'(n < 2000), 32'd1);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rstt_tx", 32'(uart_tx), 32'd1);
      chk("rstt_busy", 32'(busy), 32'd0);
      chk("rstt_psel", 32'(apb.psel), 32'd0);
      rst = 1'b0;
      repeat (80) @(negedge clk);
      $display("[TB] reset during response");

      // Frame after reset is handled normally
      xb = xfer_cnt; rb = rsp_n;
      send_write(32'h4000_0020, 32'h0102_0304);
      wait_not_busy("post_done");
      chk("post_xfers", 32'(xfer_cnt - xb), 32'd1);
      chk("post_paddr", last_addr, 32'h4000_0020);
      chk("post_pwdata", last_wdata, 32'h0102_0304);
      chk_resp("post_rsp", rb, 1, 40'hAC);
      $display("[TB] write 40000020<=01020304 resp=%0d byte(s)", rsp_n - rb);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_dbg_master.md
Name: uart_dbg_master

Overview:
- UART-to-APB debug bridge: the initiator end of the APB peripheral bus that the UART peripheral answers on.
- A host PC sends command frames over a 8N1 serial line; the block decodes them and issues single APB read or write transfers.
- It returns a status byte and, for reads, the data.
- Sits beside the CPU as a second APB master, arbitrated upstream, for bring-up and memory poking.

Parameters:
- TIMEOUT, 16'hFFFF: idle-line cycles allowed between bytes of one frame before the frame is abandoned.
- N_SYNC, 2: number of rx synchronizer flops.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- div  input  16  clocks per bit minus 1 (bit time = div+1 cycles); sampled at each start bit
- uart_rx  input  1  serial in from host, idle high
- uart_tx  output  1  serial out to host, idle high
- m_apb_intf  apb_intf.master  -  drives psel, penable, pwrite, paddr[31:0], pwdata[31:0]; reads prdata[31:0], pready, pslverr
- busy  output  1  high from first byte of a frame until last response bit is sent

Behaviour:
- Reset (rst high at a clk edge): uart_tx=1, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, busy=0; all FSMs return to IDLE, including mid-byte or mid-APB.
- Serial format is fixed 8N1, LSB first, no parity.
- RX engine:
  - Start is detected on synchronized low.
  - Start is re-checked at half bit, count {1'b0,div[15:1]}; if high there, it is a glitch and the engine returns to idle.
  - Data is sampled at mid-bit. Stop is sampled at mid-bit.
  - Stop=0 is a framing error: the byte is discarded and the frame FSM goes to F_CMD.
  - rx_vld pulses 1 cycle at the stop mid-sample.
- Frame protocol:
  - The command byte is followed by addr (4 bytes, LSB first).
  - 0x57 ('W') is write: addr, then wdata (4 bytes, LSB first).
  - 0x52 ('R') is read: addr only.
  - Any other command byte is silently dropped; the FSM stays in F_CMD.
- Frame FSM states: F_CMD, F_ADDR, F_WDATA, F_SETUP, F_ACCESS, F_RESP.
  - F_CMD -> F_ADDR on a valid command.
  - F_ADDR counts 4 bytes, then goes to F_WDATA (W) or F_SETUP (R).
  - F_WDATA counts 4 bytes -> F_SETUP.
  - F_SETUP: psel=1, penable=0, paddr/pwrite/pwdata stable; exactly 1 cycle -> F_ACCESS.
  - F_ACCESS: psel=1, penable=1; hold until pready=1. On that edge capture prdata and pslverr, drop psel/penable next cycle -> F_RESP.
  - F_RESP sends the response through the TX engine -> F_CMD once the last stop bit completes.
- Responses:
  - Read: 4 data bytes, LSB first, then status.
  - Write: status only.
  - Status is 0xAC (ok) or 0xEE (pslverr=1). Read data bytes are still sent when pslverr=1.
- Timeout:
  - In F_ADDR or F_WDATA, a gap counter increments every cycle the RX engine is idle and resets on rx_vld.
  - Reaching TIMEOUT -> F_CMD with partial data discarded; no APB transfer, no response.
- Bytes received during F_SETUP, F_ACCESS or F_RESP are dropped; no buffering, no queueing.
- TX engine:
  - Start bit, 8 data bits, 1 stop bit, each div+1 cycles.
  - Byte-to-byte with no extra idle gap.
  - uart_tx is registered.
- busy is high in every state except F_CMD-idle; it is asserted from the cycle after the command byte's rx_vld.
- APB outputs are only ever driven from registers. pwdata/paddr keep their last value while psel=0.

Decomposition:
- Package uart_dbg_pkg:
  - CMD_WR=8'h57, CMD_RD=8'h52, RSP_OK=8'hAC, RSP_ERR=8'hEE
  - frame_state_e enum (F_CMD..F_RESP)
  - bit-engine state enum (IDLE, START, DATA, STOP)
- One sub-module, uart_dbg_serdes: RX synchronizer and bit engine (rx_vld, rx_data[7:0], frm_err) plus TX bit engine (tx_vld/tx_rdy handshake, tx_data[7:0]).
- Frame FSM, gap counter and APB sequencing live in the top.

Test Plan:
- div=3; send 57 10 00 00 40 EF BE AD DE with pready=1 -> one APB write: paddr=0x40000010, pwdata=0xDEADBEEF, setup 1 cycle then access 1 cycle; uart_tx returns AC; busy low after its stop bit.
- div=3; send 52 04 00 00 40, slave holds pready=0 for 5 access cycles then prdata=0x12345678, pslverr=0 -> penable held 6 cycles; response bytes 78 56 34 12 AC.
- Read with pslverr=1, prdata=0 -> response 00 00 00 00 EE.
- Send 57 10 00 then idle for TIMEOUT=100 cycles, then 52 00 00 00 40 -> no APB write; exactly one read and one read response.
- Byte 0x57 with stop bit forced 0, then unknown byte 0x33, then a valid read frame -> first two ignored, psel never asserted before the read; read completes normally.
- Assert rst mid F_ACCESS and mid tx byte -> next cycle psel=0, penable=0, uart_tx=1, busy=0; next frame is processed correctly.
